// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: shadow scoreboard of in-flight register writes behind ID,
// producing load-use stall, taken-branch flush, registered forwarding selects and debug counters.
module pipe_hazard_ctrl #(
    parameter int REG_AW    = 5,
    parameter int NSTAGE    = 3,
    parameter int LOAD_RDY  = 3,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             id_valid,
    input  logic [REG_AW-1:0]                id_rs,
    input  logic [REG_AW-1:0]                id_rt,
    input  logic                             id_use_rs,
    input  logic                             id_use_rt,
    input  logic                             id_regwr,
    input  logic [REG_AW-1:0]                id_rw,
    input  logic                             id_load,
    input  logic                             ex_br_taken,
    output logic                             stall,
    output logic                             flush_ifid,
    output logic                             flush_idex,
    output logic [$clog2(NSTAGE+1)-1:0]      fwd_a,
    output logic [$clog2(NSTAGE+1)-1:0]      fwd_b,
    output logic [CNT_W-1:0]                 stall_cnt,
    output logic [CNT_W-1:0]                 flush_cnt
);

    localparam int SW = $clog2(NSTAGE + 1);
    localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [NSTAGE:1]    sb_valid;
    logic [NSTAGE:1]    sb_load;
    logic [REG_AW-1:0]  sb_rw [1:NSTAGE];

    logic [0:0]         state;
    logic [FW-1:0]      fcnt;

    logic [SW-1:0]      sel_a, sel_b;
    logic               haz_a, haz_b;
    logic               flushing, raw_stall, advance;

    // Youngest matching producer wins; returns {load_use_hazard, forward_select}.
    function automatic logic [SW:0] lookup(input logic [REG_AW-1:0] r);
        logic          hit;
        logic [SW-1:0] sel;
        logic          haz;
        hit = 1'b0;
        sel = '0;
        haz = 1'b0;
        for (int k = 1; k <= NSTAGE; k++) begin
            if (!hit && r != '0 && sb_valid[k] && sb_rw[k] == r) begin
                hit = 1'b1;
                sel = (k + 1 > NSTAGE) ? '0 : SW'(k + 1);
                haz = sb_load[k] && (k + 1 < LOAD_RDY);
            end
        end
        return {haz, sel};
    endfunction

    always_comb begin
        {haz_a, sel_a} = lookup(id_rs);
        {haz_b, sel_b} = lookup(id_rt);
        flushing   = ex_br_taken || (state == ST_FLUSH);
        raw_stall  = id_valid && ((id_use_rs && haz_a) || (id_use_rt && haz_b));
        stall      = !rst && !flushing && raw_stall;
        flush_ifid = !rst && flushing;
        flush_idex = !rst && flushing;
        advance    = id_valid && !stall && !flushing;
    end

    // NOTE: destination/load payload is qualified by sb_valid, so it carries no reset.
    always_ff @(posedge clk) begin
        sb_rw[1]   <= id_rw;
        sb_load[1] <= id_load;
        for (int k = 2; k <= NSTAGE; k++) begin
            sb_rw[k]   <= sb_rw[k-1];
            sb_load[k] <= sb_load[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_valid  <= '0;
            state     <= ST_RUN;
            fcnt      <= '0;
            fwd_a     <= '0;
            fwd_b     <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            sb_valid <= {sb_valid[NSTAGE:1] << 1} | {{(NSTAGE-1){1'b0}}, advance && id_regwr};

            fwd_a <= advance ? sel_a : '0;
            fwd_b <= advance ? sel_b : '0;

            // A taken branch (re)arms the countdown whatever the current state.
            if (ex_br_taken) begin
                state <= ST_FLUSH;
                fcnt  <= FW'(FLUSH_CYC - 1);
            end else if (state == ST_FLUSH) begin
                if (fcnt == '0) state <= ST_RUN;
                else            fcnt  <= fcnt - 1'b1;
            end

            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (ex_br_taken && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule
